// File: rtl/aer_event_receiver_if.sv
// aer_event_receiver_if: AER input link, downstream handshake and statistics signals
interface aer_event_receiver_if #(
  parameter int ROW_ADD    = 6,
  parameter int COL_ADD    = 6,
  parameter int SIZE       = 16,
  parameter int WIDTH      = ROW_ADD + COL_ADD + SIZE + 1,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
);
  logic                          event_valid_i;
  logic [WIDTH-1:0]              data_in_i;
  logic                          evt_ready_i;
  logic                          stat_clr_i;
  logic                          evt_valid_o;
  logic [ROW_ADD-1:0]            x_add_o;
  logic [COL_ADD-1:0]            y_add_o;
  logic [SIZE-1:0]               timestamp_o;
  logic                          polarity_o;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count_o;
  logic                          overflow_o;
  logic [CNT_W-1:0]              drop_count_o;
  modport slave (
    input  event_valid_i, data_in_i, evt_ready_i, stat_clr_i,
    output evt_valid_o, x_add_o, y_add_o, timestamp_o, polarity_o,
           fifo_count_o, overflow_o, drop_count_o
  );
  modport master (
    output event_valid_i, data_in_i, evt_ready_i, stat_clr_i,
    input  evt_valid_o, x_add_o, y_add_o, timestamp_o, polarity_o,
           fifo_count_o, overflow_o, drop_count_o
  );
endinterface

// File: rtl/aer_event_receiver.sv
// aer_event_receiver: dedups AER event runs, buffers them in a FWFT FIFO, counts overflow drops
module aer_event_receiver #(
  parameter int ROW_ADD    = 6,
  parameter int COL_ADD    = 6,
  parameter int SIZE       = 16,
  parameter int WIDTH      = ROW_ADD + COL_ADD + SIZE + 1,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input logic clk_i,
  input logic reset_i,
  aer_event_receiver_if.slave bus
);
  localparam int KW = ROW_ADD + COL_ADD + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  if (WIDTH != ROW_ADD + COL_ADD + SIZE + 1) begin : g_bad_width
    $error("WIDTH must equal ROW_ADD+COL_ADD+SIZE+1");
  end
  typedef enum logic {IDLE, RUN} state_t;
  state_t            state_q, state_d;
  logic [KW-1:0]     key, last_key_q, last_key_d;
  logic [WIDTH-1:0]  in_q, in_d, head_q, head_d;
  logic              in_vld_q, in_vld_d;
  logic [WIDTH-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic              accept, pop, push, drop, full;
  // timestamp is excluded from the key: it advances while the upstream word is held
  assign key = {bus.data_in_i[WIDTH-1 -: ROW_ADD+COL_ADD], bus.data_in_i[0]};
  always_comb begin
    accept     = bus.event_valid_i && (state_q == IDLE || key != last_key_q);
    state_d    = bus.event_valid_i ? RUN : IDLE;
    last_key_d = accept ? key : last_key_q;
    in_d       = accept ? bus.data_in_i : in_q;
    in_vld_d   = accept;
    pop        = cnt_q != '0 && bus.evt_ready_i;
    full       = cnt_q == CW'(FIFO_DEPTH);
    push       = in_vld_q && (!full || pop);
    drop       = in_vld_q && full && !pop;
    wr_d       = push ? wr_q + 1'b1 : wr_q;
    rd_d       = pop ? rd_q + 1'b1 : rd_q;
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    // head bypasses the array when the incoming word becomes the only entry
    head_d     = (pop && cnt_q > CW'(1)) ? mem_q[rd_q + 1'b1] :
                 (push && cnt_q == CW'(pop)) ? in_q : head_q;
    ovf_d      = drop || (ovf_q && !bus.stat_clr_i);
    drop_d     = bus.stat_clr_i ? CNT_W'(drop) :
                 (drop && drop_q != '1) ? drop_q + 1'b1 : drop_q;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      last_key_q <= '0;
      in_q       <= '0;
      in_vld_q   <= 1'b0;
      head_q     <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      last_key_q <= last_key_d;
      in_q       <= in_d;
      in_vld_q   <= in_vld_d;
      head_q     <= head_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= in_q;
  end
  assign bus.evt_valid_o  = cnt_q != '0;
  assign bus.x_add_o      = head_q[WIDTH-1 -: ROW_ADD];
  assign bus.y_add_o      = head_q[WIDTH-1-ROW_ADD -: COL_ADD];
  assign bus.timestamp_o  = head_q[SIZE:1];
  assign bus.polarity_o   = head_q[0];
  assign bus.fifo_count_o = cnt_q;
  assign bus.overflow_o   = ovf_q;
  assign bus.drop_count_o = drop_q;
endmodule

// File: tb/tb_aer_event_receiver.sv
// tb_aer_event_receiver: scoreboard bench for dedup, FIFO ordering, overflow and reset
module tb_aer_event_receiver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  logic [28:0] exp_q [$];
  always #5 clk = ~clk;
  aer_event_receiver_if bus();
  aer_event_receiver dut (.clk_i(clk), .reset_i(rst), .bus(bus));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic v, input logic [5:0] x, input logic [5:0] y,
                      input logic [15:0] ts, input logic p);
    bus.event_valid_i = v;
    bus.data_in_i = {x, y, ts, p};
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) step(1'b0, 6'd0, 6'd0, 16'd0, 1'b0);
  endtask
  task automatic expect_evt(input logic [5:0] x, input logic [5:0] y,
                            input logic [15:0] ts, input logic p);
    exp_q.push_back({x, y, ts, p});
  endtask
  task automatic drain(input string tag);
    bus.evt_ready_i = 1'b1;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) idle(1);
    idle(2);
    check({tag, "_left"}, exp_q.size(), 0);
    check({tag, "_cnt0"}, bus.fifo_count_o, 0);
  endtask
  always @(negedge clk) begin
    if (!rst && bus.evt_valid_o && bus.evt_ready_i) begin
      check("evt_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0)
        check("evt", {bus.x_add_o, bus.y_add_o, bus.timestamp_o, bus.polarity_o}, exp_q.pop_front());
    end
  end
  initial begin
    bus.event_valid_i = 1'b0;
    bus.data_in_i = '0;
    bus.evt_ready_i = 1'b0;
    bus.stat_clr_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", bus.evt_valid_o, 0);
    check("rst_fields", {bus.x_add_o, bus.y_add_o, bus.timestamp_o, bus.polarity_o}, 0);
    check("rst_cnt", bus.fifo_count_o, 0);
    check("rst_stats", {bus.overflow_o, bus.drop_count_o}, 0);
    rst = 1'b0;
    // 1: a held run collapses to one event with the first timestamp
    bus.evt_ready_i = 1'b1;
    expect_evt(6'd3, 6'd7, 16'd100, 1'b1);
    step(1'b1, 6'd3, 6'd7, 16'd100, 1'b1);
    check("t1_lat0", bus.evt_valid_o, 0);
    step(1'b1, 6'd3, 6'd7, 16'd101, 1'b1);
    check("t1_lat1", bus.evt_valid_o, 1);
    for (int i = 2; i < 5; i++) step(1'b1, 6'd3, 6'd7, 16'(100 + i), 1'b1);
    drain("t1");
    // 2: a gap re-arms the same key
    expect_evt(6'd5, 6'd5, 16'd10, 1'b0);
    step(1'b1, 6'd5, 6'd5, 16'd10, 1'b0);
    idle(1);
    expect_evt(6'd5, 6'd5, 16'd12, 1'b0);
    step(1'b1, 6'd5, 6'd5, 16'd12, 1'b0);
    drain("t2");
    // 3: back-to-back distinct keys
    bus.evt_ready_i = 1'b0;
    expect_evt(6'd1, 6'd1, 16'd20, 1'b0);
    step(1'b1, 6'd1, 6'd1, 16'd20, 1'b0);
    expect_evt(6'd1, 6'd2, 16'd21, 1'b0);
    step(1'b1, 6'd1, 6'd2, 16'd21, 1'b0);
    expect_evt(6'd2, 6'd2, 16'd22, 1'b1);
    step(1'b1, 6'd2, 6'd2, 16'd22, 1'b1);
    idle(2);
    check("t3_cnt", bus.fifo_count_o, 3);
    drain("t3");
    // 4: overflow with 10 pushes into 8 entries
    bus.evt_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) expect_evt(6'(10 + i), 6'(i), 16'(200 + i), i[0]);
      step(1'b1, 6'(10 + i), 6'(i), 16'(200 + i), i[0]);
    end
    idle(2);
    check("t4_cnt", bus.fifo_count_o, 8);
    check("t4_drop", bus.drop_count_o, 2);
    check("t4_ovf", bus.overflow_o, 1);
    check("t4_head", {bus.x_add_o, bus.y_add_o, bus.timestamp_o, bus.polarity_o},
          {6'd10, 6'd0, 16'd200, 1'b0});
    check("t4_hold", {bus.evt_valid_o, bus.x_add_o}, {1'b1, 6'd10});
    drain("t4");
    // 5: full FIFO with simultaneous push and pop, then clear colliding with a drop
    bus.evt_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      expect_evt(6'(20 + i), 6'(i), 16'(300 + i), 1'b1);
      step(1'b1, 6'(20 + i), 6'(i), 16'(300 + i), 1'b1);
    end
    idle(2);
    check("t5_full", bus.fifo_count_o, 8);
    expect_evt(6'd30, 6'd9, 16'd308, 1'b1);
    step(1'b1, 6'd30, 6'd9, 16'd308, 1'b1);
    bus.evt_ready_i = 1'b1;
    idle(1);
    bus.evt_ready_i = 1'b0;
    check("t5_cnt", bus.fifo_count_o, 8);
    check("t5_nodrop", bus.drop_count_o, 2);
    step(1'b1, 6'd31, 6'd9, 16'd309, 1'b1);
    bus.stat_clr_i = 1'b1;
    idle(1);
    bus.stat_clr_i = 1'b0;
    check("t5_clr_drop", bus.drop_count_o, 1);
    check("t5_clr_ovf", bus.overflow_o, 1);
    drain("t5");
    // 6: reset mid-operation while the last key is still held upstream
    bus.evt_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b1, 6'(40 + i), 6'(i), 16'(400 + i), i[0]);
    step(1'b1, 6'd44, 6'd4, 16'd405, 1'b0);
    check("t6_cnt5", bus.fifo_count_o, 5);
    exp_q.delete();
    rst = 1'b1;
    step(1'b1, 6'd44, 6'd4, 16'd406, 1'b0);
    rst = 1'b0;
    check("t6_valid", bus.evt_valid_o, 0);
    check("t6_cnt", bus.fifo_count_o, 0);
    check("t6_ovf", bus.overflow_o, 0);
    check("t6_drop", bus.drop_count_o, 0);
    bus.evt_ready_i = 1'b1;
    expect_evt(6'd44, 6'd4, 16'd407, 1'b0);
    step(1'b1, 6'd44, 6'd4, 16'd407, 1'b0);
    step(1'b1, 6'd44, 6'd4, 16'd408, 1'b0);
    drain("t6");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
